voice_scheduler: RTL



---
 rtl/voice_scheduler.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/voice_scheduler.sv
// Per-sample voice sequencer: captures note state on a tick, starts each voice in turn,
// routes the active voice onto the shared multiplier/divider buses and mixes the outputs.
module voice_scheduler #(
    parameter int NUM_VOICES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_tick,
    input  logic [NUM_VOICES-1:0]      gate_in,
    input  logic [NUM_VOICES-1:0]      note_on,
    input  logic [24*NUM_VOICES-1:0]   freq_in,
    output logic [NUM_VOICES-1:0]      voice_start,
    input  logic [NUM_VOICES-1:0]      voice_finish,
    input  logic [24*NUM_VOICES-1:0]   voice_wave,
    output logic [NUM_VOICES-1:0]      voice_gate,
    output logic [NUM_VOICES-1:0]      voice_trigger,
    output logic [24*NUM_VOICES-1:0]   voice_freq,
    input  logic [32*NUM_VOICES-1:0]   voice_mult_a,
    input  logic [32*NUM_VOICES-1:0]   voice_mult_b,
    input  logic [48*NUM_VOICES-1:0]   voice_div_n,
    input  logic [48*NUM_VOICES-1:0]   voice_div_d,
    output logic [31:0]                mult_a,
    output logic [31:0]                mult_b,
    output logic [47:0]                div_n,
    output logic [47:0]                div_d,
    output logic [23:0]                mix_out,
    output logic                       mix_valid,
    output logic                       busy,
    output logic                       overrun,
    output logic [1:0]                 fsm_state
);

    localparam int IW = $clog2(NUM_VOICES);
    localparam int AW = 24 + IW;
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-23){1'b0}}, {23{1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-23){1'b1}}, {23{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_START   = 2'd2,
        S_WAIT    = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [IW-1:0]          idx;
    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   wave_ext;
    logic signed [AW-1:0]   sum;
    logic [23:0]            sum_sat;
    logic [23:0]            wave_sel;
    logic [NUM_VOICES-1:0]  pending;
    logic                   finish_sel;
    logic                   last_voice;
    logic                   routing;

    // Handshake: voice_start[idx] is a single-cycle pulse in START; the scheduler then waits in
    // WAIT for a single-cycle voice_finish[idx] from that voice only, other finish bits are ignored.
    assign finish_sel = voice_finish[idx];
    assign last_voice = (idx == IW'(NUM_VOICES - 1));
    assign wave_sel   = voice_wave[24*int'(idx) +: 24];
    assign wave_ext   = {{(AW-24){wave_sel[23]}}, wave_sel};
    assign sum        = acc + wave_ext;

    always_comb begin
        sum_sat = sum[23:0];
        if (sum > SAT_MAX) begin
            sum_sat = 24'h7FFFFF;
        end else if (sum < SAT_MIN) begin
            sum_sat = 24'h800000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (sample_tick) state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_START;
            S_START:   state_next = S_WAIT;
            S_WAIT:    if (finish_sel) state_next = last_voice ? S_IDLE : S_START;
            default:   state_next = S_IDLE;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign fsm_state = state;
    assign routing   = (state == S_START) || (state == S_WAIT);

    always_comb begin
        voice_start = '0;
        if (state == S_START) begin
            voice_start[idx] = 1'b1;
        end
    end

    // Shared buses follow the registered voice index, so they are glitch-free for the whole slot.
    always_comb begin
        mult_a = '0;
        mult_b = '0;
        div_n  = '0;
        div_d  = '0;
        if (routing) begin
            mult_a = voice_mult_a[32*int'(idx) +: 32];
            mult_b = voice_mult_b[32*int'(idx) +: 32];
            div_n  = voice_div_n[48*int'(idx) +: 48];
            div_d  = voice_div_d[48*int'(idx) +: 48];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx           <= '0;
            acc           <= '0;
            pending       <= '0;
            voice_gate    <= '0;
            voice_trigger <= '0;
            voice_freq    <= '0;
            mix_out       <= '0;
            mix_valid     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            if (sample_tick && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end
            // A note_on arriving during CAPTURE goes straight into this frame's triggers.
            if (state == S_CAPTURE) begin
                pending <= '0;
            end else begin
                pending <= pending | note_on;
            end
            case (state)
                S_CAPTURE: begin
                    voice_gate    <= gate_in;
                    voice_freq    <= freq_in;
                    voice_trigger <= pending | note_on;
                    acc           <= '0;
                    idx           <= '0;
                end
                S_WAIT: begin
                    if (finish_sel) begin
                        if (last_voice) begin
                            mix_out   <= sum_sat;
                            mix_valid <= 1'b1;
                            acc       <= '0;
                        end else begin
                            acc <= sum;
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
